cplx_stim_gen: RTL

//  Synthesizable stimulus source for the complex multiplier bench. It consumes clk/rst_n

---
 rtl/cplx_stim_gen.sv | 104 ++++++++++
 1 files changed

// File: rtl/cplx_stim_gen.sv
// Pseudo-random complex operand source (a=ar+j*ai, b=br+j*bi) for the complex multiplier bench.
// Latency: first op_valid after the (START_DLY+2)th edge past reset release, then 1 txn/cycle.
// Backpressure: op_valid and operands hold while op_ready is low; en only gates new issues.
module cplx_stim_gen #(
  parameter int          DATA_W    = 8,
  parameter int          NUM_TXN   = 16,
  parameter int          START_DLY = 4,
  parameter logic [31:0] SEED      = 32'h00000001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              restart,
  input  logic              op_ready,
  output logic              op_valid,
  output logic [DATA_W-1:0] op_ar,
  output logic [DATA_W-1:0] op_ai,
  output logic [DATA_W-1:0] op_br,
  output logic [DATA_W-1:0] op_bi,
  output logic [15:0]       txn_cnt,
  output logic              done
);

  // An all-zero LFSR would lock up, so a zero seed falls back to 1.
  localparam logic [31:0] SEED_EFF    = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [15:0] NUM_TXN_W   = 16'(NUM_TXN);
  localparam logic [7:0]  START_DLY_W = 8'(START_DLY);
  localparam bit          RUN_FOREVER = (NUM_TXN == 0);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t      state;
  logic [7:0]  dly_cnt;
  logic [31:0] lfsr;
  logic        fire;
  logic        last;
  logic        lfsr_fb;

  assign fire    = op_valid & op_ready;
  assign last    = !RUN_FOREVER && ((txn_cnt + 16'd1) == NUM_TXN_W);
  assign lfsr_fb = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];

  // Operands are direct slices of the LFSR, so they only move on a handshake.
  assign op_ar = lfsr[DATA_W-1:0];
  assign op_ai = lfsr[2*DATA_W-1:DATA_W];
  assign op_br = lfsr[3*DATA_W-1:2*DATA_W];
  assign op_bi = lfsr[4*DATA_W-1:3*DATA_W];

  // Settle delay, issue/accept sequencing and run completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_WAIT;
      dly_cnt  <= 8'd0;
      lfsr     <= SEED_EFF;
      op_valid <= 1'b0;
      txn_cnt  <= 16'd0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          dly_cnt <= dly_cnt + 8'd1;
          if (dly_cnt == START_DLY_W) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (fire) begin
            lfsr <= {lfsr[30:0], lfsr_fb};
            if (txn_cnt != 16'hFFFF) begin
              txn_cnt <= txn_cnt + 16'd1;
            end
            if (last) begin
              op_valid <= 1'b0;
              done     <= 1'b1;
              state    <= ST_DONE;
            end else begin
              op_valid <= en;
            end
          end else if (!op_valid) begin
            // A pending op_valid is never retracted; only an idle slot may issue.
            op_valid <= en;
          end
        end
        ST_DONE: begin
          if (restart) begin
            state   <= ST_RUN;
            txn_cnt <= 16'd0;
            done    <= 1'b0;
            lfsr    <= SEED_EFF;
          end
        end
        default: begin
          state    <= ST_WAIT;
          op_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
